// File: rtl/function_arbiter_pkg.sv
// Shared types and constants for the clocked function arbiter.
package function_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

endpackage

// File: rtl/function_arbiter_if.sv
// Request/grant bundle between async requesters, the arbiter and the granted function.
interface function_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned W = $clog2(N);

    logic [N-1:0] reqs;
    logic         done;
    logic [N-1:0] sets;
    logic [W-1:0] sel;
    logic         fin;
    logic         busy;
    logic [N-1:0] dropped;

    modport master (
        output reqs, done,
        input  sets, sel, fin, busy, dropped
    );

    modport slave (
        input  reqs, done,
        output sets, sel, fin, busy, dropped
    );

endinterface

// File: rtl/function_arbiter_sync_edge.sv
// Per-line synchroniser followed by a registered rising-edge detector.
module req_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], a_in};
            prev  <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/function_arbiter.sv
// Captures async request edges as pending bits and grants one function at a time
// with a 4-phase fin/done handshake, fixed-priority or round-robin.
module function_arbiter
    import function_arbiter_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned MODE        = MODE_FIXED,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    function_arbiter_if.slave bus
);

    localparam int unsigned W = $clog2(N);

    logic [N-1:0] rise;
    logic [N-1:0] pending;
    logic [W-1:0] ptr;
    arb_state_t   state;

    logic [N-1:0] sets_q;
    logic [W-1:0] sel_q;
    logic         fin_q;
    logic         busy_q;
    logic [N-1:0] dropped_q;

    logic         any_c;
    logic [W-1:0] win_c;
    logic [N-1:0] win_oh_c;
    logic [N-1:0] clr_c;
    logic [W-1:0] ptr_next_c;

    for (genvar i = 0; i < int'(N); i++) begin : g_sync
        req_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .a_in(bus.reqs[i]),
            .rise(rise[i])
        );
    end

    // Winner: rotate pending by ptr and priority-encode for round-robin, plain encode otherwise.
    always_comb begin
        logic [2*N-1:0] doubled;
        logic [N-1:0]   rotated;
        int unsigned    off;
        int unsigned    sum;
        doubled = {pending, pending};
        rotated = '0;
        off     = 0;
        sum     = 0;
        win_c   = '0;
        if (MODE == MODE_RR) begin
            rotated = N'(doubled >> ptr);
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (rotated[i]) off = unsigned'(i);
            end
            sum = off + 32'(ptr);
            if (sum >= N) sum = sum - N;
            win_c = W'(sum);
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pending[i]) win_c = W'(i);
            end
        end
    end

    assign any_c      = |pending;
    assign win_oh_c   = N'(1) << win_c;
    assign clr_c      = (state == IDLE && any_c) ? win_oh_c : '0;
    assign ptr_next_c = (32'(win_c) == N - 1) ? '0 : W'(32'(win_c) + 1);

    // A fresh edge on the channel being granted this cycle re-arms it rather than dropping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            ptr       <= '0;
            sets_q    <= '0;
            sel_q     <= '0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            pending   <= (pending & ~clr_c) | rise;
            dropped_q <= rise & pending & ~clr_c;
            case (state)
                IDLE: begin
                    if (any_c) begin
                        state  <= GRANT;
                        sets_q <= win_oh_c;
                        sel_q  <= win_c;
                        fin_q  <= 1'b1;
                        busy_q <= 1'b1;
                        if (MODE == MODE_RR) ptr <= ptr_next_c;
                    end
                end
                GRANT: begin
                    if (bus.done) begin
                        state  <= RELEASE;
                        sets_q <= '0;
                        fin_q  <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!bus.done) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sets_q <= '0;
                    fin_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sets    = sets_q;
    assign bus.sel     = sel_q;
    assign bus.fin     = fin_q;
    assign bus.busy    = busy_q;
    assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_function_arbiter.sv
// Directed bench for function_arbiter: one fixed-priority and one round-robin instance,
// each shadowed by a request-level model that is compared every cycle.
module tb_function_arbiter;
    import function_arbiter_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned S = 2;

    logic clk;
    logic rst;

    function_arbiter_if #(.N(N)) if_fx ();
    function_arbiter_if #(.N(N)) if_rr ();

    function_arbiter #(.N(N), .MODE(MODE_FIXED), .SYNC_STAGES(S)) u_fx (
        .clk(clk), .rst(rst), .bus(if_fx.slave)
    );
    function_arbiter #(.N(N), .MODE(MODE_RR), .SYNC_STAGES(S)) u_rr (
        .clk(clk), .rst(rst), .bus(if_rr.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state, index 0 = fixed instance, 1 = round-robin instance.
    logic [N-1:0] hist   [2][S+2];
    logic [N-1:0] m_pend [2];
    int           m_state[2];
    int           m_ptr  [2];
    logic [N-1:0] m_sets [2];
    int           m_sel  [2];
    logic         m_fin  [2];
    logic         m_busy [2];
    logic [N-1:0] m_drop [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = 0;
    int drop_cnt[N];
    int drop_ref[N];

    task automatic model_reset(input int u);
        for (int j = 0; j < int'(S) + 2; j++) hist[u][j] = '0;
        m_pend[u]  = '0;
        m_state[u] = 0;
        m_ptr[u]   = 0;
        m_sets[u]  = '0;
        m_sel[u]   = 0;
        m_fin[u]   = 1'b0;
        m_busy[u]  = 1'b0;
        m_drop[u]  = '0;
    endtask

    // A request level seen S+1 samples ago that was low one sample before that is a new request.
    task automatic model_step(input int u, input logic [N-1:0] r, input logic d, input bit rr);
        logic [N-1:0] det;
        logic [N-1:0] clr;
        int           w;
        int           c;
        det = hist[u][S] & ~hist[u][S+1];
        clr = '0;
        if (m_state[u] == 0) begin
            if (m_pend[u] != '0) begin
                w = -1;
                for (int k = 0; k < int'(N); k++) begin
                    c = rr ? (m_ptr[u] + k) % int'(N) : k;
                    if (w < 0 && m_pend[u][c]) w = c;
                end
                clr[w]     = 1'b1;
                m_sets[u]  = clr;
                m_sel[u]   = w;
                m_fin[u]   = 1'b1;
                m_busy[u]  = 1'b1;
                m_state[u] = 1;
                if (rr) m_ptr[u] = (w + 1) % int'(N);
            end
        end else if (m_state[u] == 1) begin
            if (d) begin
                m_state[u] = 2;
                m_sets[u]  = '0;
                m_fin[u]   = 1'b0;
            end
        end else begin
            if (!d) begin
                m_state[u] = 0;
                m_busy[u]  = 1'b0;
            end
        end
        m_drop[u] = det & m_pend[u] & ~clr;
        m_pend[u] = (m_pend[u] & ~clr) | det;
        for (int j = int'(S) + 1; j > 0; j--) hist[u][j] = hist[u][j-1];
        hist[u][0] = r;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, if_fx.reqs, if_fx.done, 1'b0);
            model_step(1, if_rr.reqs, if_rr.done, 1'b1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("fx.sets",    32'(if_fx.sets),    32'(m_sets[0]));
        chk("fx.sel",     32'(if_fx.sel),     32'(m_sel[0]));
        chk("fx.fin",     32'(if_fx.fin),     32'(m_fin[0]));
        chk("fx.busy",    32'(if_fx.busy),    32'(m_busy[0]));
        chk("fx.dropped", 32'(if_fx.dropped), 32'(m_drop[0]));
        chk("rr.sets",    32'(if_rr.sets),    32'(m_sets[1]));
        chk("rr.sel",     32'(if_rr.sel),     32'(m_sel[1]));
        chk("rr.fin",     32'(if_rr.fin),     32'(m_fin[1]));
        chk("rr.busy",    32'(if_rr.busy),    32'(m_busy[1]));
        chk("rr.dropped", 32'(if_rr.dropped), 32'(m_drop[1]));
    endtask

    // Every cycle of the run passes through here: compare 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        compare_all();
        for (int i = 0; i < int'(N); i++) if (if_fx.dropped[i]) drop_cnt[i]++;
    endtask

    task automatic mark();
        base = cyc + 1;
    endtask

    task automatic goto(input int k);
        while (cyc < base + k) step();
    endtask

    task automatic snap_drops();
        for (int i = 0; i < int'(N); i++) drop_ref[i] = drop_cnt[i];
    endtask

    task automatic chk_drops(input string name, input logic [N-1:0] mask);
        for (int i = 0; i < int'(N); i++)
            chk(name, 32'(drop_cnt[i] - drop_ref[i]), mask[i] ? 32'd1 : 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < int'(N); i++) drop_cnt[i] = 0;
        if_fx.reqs = '0;
        if_fx.done = 1'b0;
        if_rr.reqs = '0;
        if_rr.done = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        step();
        step();
        chk("rst.sets", 32'(if_fx.sets), 32'h0);
        chk("rst.fin",  32'(if_fx.fin),  32'h0);
        chk("rst.busy", 32'(if_rr.busy), 32'h0);
        rst = 1'b0;
        mark();
        goto(4);

        // Single request: ch2 granted on edge 4, released one edge after done.
        if_fx.reqs[2] = 1'b1;
        mark();
        goto(4);
        chk("t1.sets", 32'(if_fx.sets), 32'h4);
        chk("t1.sel",  32'(if_fx.sel),  32'd2);
        chk("t1.fin",  32'(if_fx.fin),  32'd1);
        goto(7);
        if_fx.done    = 1'b1;
        if_fx.reqs[2] = 1'b0;
        goto(8);
        chk("t1.rel_sets", 32'(if_fx.sets), 32'h0);
        chk("t1.rel_fin",  32'(if_fx.fin),  32'd0);
        chk("t1.rel_sel",  32'(if_fx.sel),  32'd2);
        chk("t1.rel_busy", 32'(if_fx.busy), 32'd1);
        if_fx.done = 1'b0;
        goto(9);
        chk("t1.idle_busy", 32'(if_fx.busy), 32'd0);
        goto(13);

        // Fixed priority: ch3 and ch1 together -> ch1 then ch3, nothing dropped.
        snap_drops();
        if_fx.reqs = 4'b1010;
        mark();
        goto(4);
        chk("t2.first", 32'(if_fx.sets), 32'h2);
        if_fx.reqs = '0;
        if_fx.done = 1'b1;
        goto(5);
        if_fx.done = 1'b0;
        goto(7);
        chk("t2.second", 32'(if_fx.sets), 32'h8);
        chk("t2.sel",    32'(if_fx.sel),  32'd3);
        if_fx.done = 1'b1;
        goto(8);
        if_fx.done = 1'b0;
        goto(10);
        chk("t2.busy", 32'(if_fx.busy), 32'd0);
        chk_drops("t2.drops", 4'b0000);
        goto(14);

        // Drop: ch0 edges twice while ch2 is held in GRANT.
        snap_drops();
        if_fx.reqs[2] = 1'b1;
        mark();
        goto(4);
        chk("t3.grant2", 32'(if_fx.sets), 32'h4);
        if_fx.reqs[2] = 1'b0;
        if_fx.reqs[0] = 1'b1;
        goto(8);
        if_fx.reqs[0] = 1'b0;
        goto(12);
        if_fx.reqs[0] = 1'b1;
        goto(16);
        chk("t3.drop_pulse", 32'(if_fx.dropped), 32'h1);
        if_fx.reqs[0] = 1'b0;
        goto(17);
        chk("t3.drop_end", 32'(if_fx.dropped), 32'h0);
        goto(20);
        if_fx.done = 1'b1;
        goto(21);
        if_fx.done = 1'b0;
        goto(23);
        chk("t3.grant0", 32'(if_fx.sets), 32'h1);
        if_fx.done = 1'b1;
        goto(24);
        if_fx.done = 1'b0;
        goto(30);
        chk("t3.no_regrant", 32'(if_fx.busy), 32'd0);
        chk_drops("t3.drops", 4'b0001);
        goto(34);

        // Same-cycle re-request: ch1's second edge lands on the edge ch1 is granted.
        snap_drops();
        if_fx.reqs[0] = 1'b1;
        mark();
        goto(4);
        chk("t4.grant0", 32'(if_fx.sets), 32'h1);
        if_fx.reqs[0] = 1'b0;
        if_fx.reqs[1] = 1'b1;
        goto(8);
        if_fx.reqs[1] = 1'b0;
        goto(11);
        if_fx.reqs[1] = 1'b1;
        goto(12);
        if_fx.done = 1'b1;
        goto(13);
        if_fx.done = 1'b0;
        goto(15);
        chk("t4.grant1", 32'(if_fx.sets),    32'h2);
        chk("t4.nodrop", 32'(if_fx.dropped), 32'h0);
        if_fx.reqs[1] = 1'b0;
        goto(16);
        if_fx.done = 1'b1;
        goto(17);
        if_fx.done = 1'b0;
        goto(19);
        chk("t4.regrant1", 32'(if_fx.sets), 32'h2);
        chk("t4.regrant_fin", 32'(if_fx.fin), 32'd1);
        goto(20);
        if_fx.done = 1'b1;
        goto(21);
        if_fx.done = 1'b0;
        goto(24);
        chk("t4.busy", 32'(if_fx.busy), 32'd0);
        chk_drops("t4.drops", 4'b0000);
        goto(27);

        // Reset mid-GRANT clears outputs without a clock; re-raised ch1 granted 4 edges later.
        if_fx.reqs[1] = 1'b1;
        mark();
        goto(4);
        chk("t5.pre_sets", 32'(if_fx.sets), 32'h2);
        if_fx.reqs[1] = 1'b0;
        goto(5);
        #1 rst = 1'b1;
        #1;
        chk("t5.async_sets", 32'(if_fx.sets), 32'h0);
        chk("t5.async_fin",  32'(if_fx.fin),  32'd0);
        chk("t5.async_busy", 32'(if_fx.busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        if_fx.reqs[1] = 1'b1;
        mark();
        goto(3);
        chk("t5.not_yet", 32'(if_fx.fin), 32'd0);
        goto(4);
        chk("t5.regrant", 32'(if_fx.sets), 32'h2);
        if_fx.reqs[1] = 1'b0;
        if_fx.done    = 1'b1;
        goto(5);
        if_fx.done = 1'b0;
        goto(9);

        // Round-robin: all four request, ch0 re-requests after its grant -> 0,1,2,3,0.
        if_rr.reqs = 4'b1111;
        mark();
        for (int k = 0; k < 5; k++) begin
            goto(4 + 3 * k);
            chk("t6.sel", 32'(if_rr.sel), 32'(exp_rr[k]));
            chk("t6.fin", 32'(if_rr.fin), 32'd1);
            if (k == 0) if_rr.reqs = '0;
            if_rr.done = 1'b1;
            goto(5 + 3 * k);
            if_rr.done = 1'b0;
            if (5 + 3 * k == 5)  if_rr.reqs[0] = 1'b1;
            if (5 + 3 * k == 11) if_rr.reqs[0] = 1'b0;
        end
        goto(22);
        chk("t6.busy", 32'(if_rr.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
